adc_conv_sequencer: RTL

Scan scheduler that sits in front of the dual-slope conversion FSM and shares it across up to NUM_CH analog channels. At a programmable interval it walks the enabled channels in ascending order. For each channel it:
- selects the channel;
- waits for the analog front-end to settle;
- pulses `trigger`;
- waits for the conversion-done interrupt;
- captures the count;
- pulses `interrupt_clear`.

Results leave as one-cycle valid pulses tagged with their channel number.

---
 rtl/adc_conv_sequencer_if.sv | 47 ++++
 rtl/adc_conv_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_sequencer_if.sv
// adc_conv_sequencer_if
//   Bundles the scan-control, analog front-end and conversion-FSM signals of
//   the ADC conversion sequencer.
//   slave  : sequencer side (control/front-end/conversion inputs in,
//            mux select, trigger, acknowledge and results out)
//   master : environment side (the opposite directions)
//   Signals keep their _i/_o suffixes as seen from the sequencer.
interface adc_conv_sequencer_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    // Scan control
    logic              enable_i;
    logic [NUM_CH-1:0] ch_mask_i;
    logic [CNT_W-1:0]  period_i;

    // Analog front-end and conversion FSM
    logic              analog_ready_i;
    logic              conv_done_i;
    logic [CNT_W-1:0]  result_i;

    // Sequencer outputs
    logic [CH_W-1:0]   ch_sel_o;
    logic              trigger_o;
    logic              interrupt_clear_o;
    logic              res_valid_o;
    logic [CH_W-1:0]   res_ch_o;
    logic [CNT_W-1:0]  res_data_o;
    logic              busy_o;
    logic              timeout_o;

    modport slave (
        input  enable_i, ch_mask_i, period_i,
        input  analog_ready_i, conv_done_i, result_i,
        output ch_sel_o, trigger_o, interrupt_clear_o,
        output res_valid_o, res_ch_o, res_data_o, busy_o, timeout_o
    );

    modport master (
        output enable_i, ch_mask_i, period_i,
        output analog_ready_i, conv_done_i, result_i,
        input  ch_sel_o, trigger_o, interrupt_clear_o,
        input  res_valid_o, res_ch_o, res_data_o, busy_o, timeout_o
    );
endinterface

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer
//   Scan scheduler that shares one dual-slope conversion FSM across NUM_CH
//   analog channels. Every period_i cycles it walks the channels enabled in
//   the mask latched at scan start, in ascending order: select, wait for the
//   front-end to settle, trigger, wait for conversion done, capture, clear.
//   Each result leaves as a one-cycle res_valid_o pulse tagged with its channel.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   bus (slave)  : enable_i, ch_mask_i, period_i, analog_ready_i, conv_done_i,
//                  result_i in; ch_sel_o, trigger_o, interrupt_clear_o,
//                  res_valid_o, res_ch_o, res_data_o, busy_o, timeout_o out
//
// Build option
//   ADC_SEQ_TIMEOUT_EN : when defined, a conversion that does not finish
//   within TIMEOUT WAIT_DONE cycles is abandoned with an interrupt clear and
//   a sticky timeout_o. When undefined WAIT_DONE waits forever and
//   timeout_o is tied low.
module adc_conv_sequencer #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    adc_conv_sequencer_if.slave  bus
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    // Elaboration-time parameter range checks
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("adc_conv_sequencer: NUM_CH must be 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("adc_conv_sequencer: TIMEOUT must be at least 1");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_SELECT,
        S_SETTLE,
        S_TRIG,
        S_WAIT_DONE,
        S_ACK,
        S_WAIT_CLR,
        S_WAIT_PERIOD
    } state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] mask_q;
    logic [CNT_W-1:0]  period_cnt_q;
    logic [CH_W-1:0]   ch_sel_q;
    logic [CH_W-1:0]   res_ch_q;
    logic [CNT_W-1:0]  res_data_q;
    logic              trigger_q;
    logic              clr_q;
    logic              res_valid_q;
    logic              busy_q;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              timeout_q;
`endif

    // Lowest pending channel of the latched mask
    logic              pick_hit;
    logic [CH_W-1:0]   pick_idx;

    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        // Descending walk so the lowest set bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                pick_hit = 1'b1;
                pick_idx = CH_W'(i);
            end
        end
    end

    // Saturating period counter helpers
    logic [CNT_W-1:0]  period_dec;
    logic [CNT_W-1:0]  period_load;
    logic              period_due;

    assign period_dec  = (period_cnt_q == '0) ? '0 : period_cnt_q - CNT_W'(1);
    // The START cycle itself is the first elapsed cycle of the period.
    assign period_load = (bus.period_i == '0) ? '0 : bus.period_i - CNT_W'(1);
    // Counter reaches zero on this edge: the next scan is due in the next cycle,
    // which puts consecutive STARTs exactly period_i cycles apart.
    assign period_due  = (period_cnt_q <= CNT_W'(1));

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            period_cnt_q <= '0;
            ch_sel_q     <= '0;
            res_ch_q     <= '0;
            res_data_q   <= '0;
            trigger_q    <= 1'b0;
            clr_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            trigger_q   <= 1'b0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;

            if (state_q != S_IDLE) begin
                period_cnt_q <= period_dec;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.enable_i) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    mask_q       <= bus.ch_mask_i;
                    period_cnt_q <= period_load;
                    state_q      <= S_SELECT;
                end

                S_SELECT: begin
                    if (pick_hit) begin
                        ch_sel_q         <= pick_idx;
                        mask_q[pick_idx] <= 1'b0;
                        state_q          <= S_SETTLE;
                    end else begin
                        state_q <= S_WAIT_PERIOD;
                        busy_q  <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (bus.analog_ready_i) begin
                        trigger_q <= 1'b1;
                        state_q   <= S_TRIG;
                    end
                end

                // conv_done_i is deliberately not looked at here: a level left
                // over from a previous conversion must not be captured.
                S_TRIG: begin
                    state_q <= S_WAIT_DONE;
`ifdef ADC_SEQ_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end

                S_WAIT_DONE: begin
                    if (bus.conv_done_i) begin
                        res_data_q  <= bus.result_i;
                        res_ch_q    <= ch_sel_q;
                        res_valid_q <= 1'b1;
                        clr_q       <= 1'b1;
                        state_q     <= S_ACK;
                    end
`ifdef ADC_SEQ_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        // Abandon the channel: acknowledge without a result.
                        timeout_q <= 1'b1;
                        clr_q     <= 1'b1;
                        state_q   <= S_SELECT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end

                S_ACK: begin
                    state_q <= S_WAIT_CLR;
                end

                S_WAIT_CLR: begin
                    if (!bus.conv_done_i) begin
                        state_q <= S_SELECT;
                    end
                end

                S_WAIT_PERIOD: begin
                    if (period_due) begin
                        if (bus.enable_i) begin
                            state_q <= S_START;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ch_sel_o          = ch_sel_q;
    assign bus.trigger_o         = trigger_q;
    assign bus.interrupt_clear_o = clr_q;
    assign bus.res_valid_o       = res_valid_q;
    assign bus.res_ch_o          = res_ch_q;
    assign bus.res_data_o        = res_data_q;
    assign bus.busy_o            = busy_q;
`ifdef ADC_SEQ_TIMEOUT_EN
    assign bus.timeout_o         = timeout_q;
`else
    assign bus.timeout_o         = 1'b0;
`endif

endmodule
